window_fifo: RTL and testbench

//  Circular data buffer for the convolution datapath, built around two wrap-around

---
 rtl/window_fifo.sv | 93 +++++++++
 tb/tb_window_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/window_fifo.sv
// Circular word buffer between the pixel/weight source and the MAC array.
// Storage is addressed by wrap-around pointers and drains through a registered prefetch stage.
module window_fifo #(
  parameter int unsigned BufferWidth = 2,
  parameter int unsigned DataWidth   = 8
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  input  logic                   sclr,
  input  logic                   in_valid,
  input  logic [DataWidth-1:0]   in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DataWidth-1:0]   out_data,
  input  logic                   out_ready,
  output logic [BufferWidth:0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned Depth = 2 ** BufferWidth;
  localparam int unsigned CntW  = BufferWidth + 1;

  logic [DataWidth-1:0]   mem_q [Depth];
  logic [BufferWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [BufferWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   out_valid_q, out_valid_d;
  logic [DataWidth-1:0]   out_data_q, out_data_d;
  logic                   push, load;

  // Status decodes come from registered state only, so no in->out combinational path.
  assign full      = (count_q == CntW'(Depth));
  assign empty     = (count_q == '0) && !out_valid_q;
  assign in_ready  = !full;
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign push = in_valid && !full;
  assign load = (count_q != '0) && (!out_valid_q || out_ready);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (sclr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + BufferWidth'(1);
      end
      if (load) begin
        rd_ptr_d    = rd_ptr_q + BufferWidth'(1);
        out_data_d  = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      count_d = count_q + CntW'(push) - CntW'(load);
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage is deliberately left out of both resets.
  always_ff @(posedge clk) begin
    if (push && !sclr) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_window_fifo.sv
// Scoreboard bench for window_fifo: accepted words are queued and checked in order
// as they leave the output register; status, latency and hold behaviour are checked directly.
module tb_window_fifo;

  logic       clk;
  logic       aclr_n;
  logic       sclr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb_q[$];
  logic        held_v = 1'b0;
  logic [7:0]  held_d = 8'h00;

  window_fifo #(.BufferWidth(2), .DataWidth(8)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .sclr      (sclr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle starting mid-cycle: drive, score the handshakes, advance to next negedge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic sc);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    sclr      = sc;
    #1;
    if (held_v) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", 32'(out_data), 32'(held_d));
    end
    if (sc) begin
      sb_q.delete();
      held_v = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check_eq("pop_unexpected", 32'd1, 32'd0);
        else check_eq("out_data", 32'(out_data), 32'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) sb_q.push_back(d);
      held_v = out_valid && !out_ready;
      held_d = out_data;
    end
    @(negedge clk);
  endtask

  task automatic idle_drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    aclr_n    = 1'b0;
    sclr      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    aclr_n = 1'b1;

    // Latency: one word, output register free
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check_eq("lat_e0_count", 32'(count), 32'd1);
    check_eq("lat_e0_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("lat_e1_valid", 32'(out_valid), 32'd1);
    check_eq("lat_e1_data", 32'(out_data), 32'hA5);
    check_eq("lat_e1_count", 32'(count), 32'd0);
    idle_drain(2);

    // Fill: output register plus four storage words
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    check_eq("fill_out_data", 32'(out_data), 32'h01);
    cycle(1'b1, 8'h06, 1'b0, 1'b0);
    check_eq("fill_sixth_count", 32'(count), 32'd4);
    idle_drain(7);

    // Streaming: one word per cycle, pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      if (i >= 1) begin
        check_eq("stream_count", 32'(count), 32'd1);
        check_eq("stream_valid", 32'(out_valid), 32'd1);
      end
    end
    idle_drain(4);

    // Back-pressure: random out_ready under continuous input
    for (int i = 0; i < 80; i++) cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    idle_drain(8);

    // Synchronous clear with traffic requested on both sides
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check_eq("pre_sclr_count", 32'(count), 32'd3);
    check_eq("pre_sclr_valid", 32'(out_valid), 32'd1);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    check_eq("sclr_count", 32'(count), 32'd0);
    check_eq("sclr_valid", 32'(out_valid), 32'd0);
    check_eq("sclr_empty", 32'(empty), 32'd1);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("post_sclr_data", 32'(out_data), 32'h77);
    idle_drain(3);

    // Asynchronous reset asserted mid-cycle while words are in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    #2;
    aclr_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_empty", 32'(empty), 32'd1);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    held_v = 1'b0;
    @(negedge clk);
    aclr_n = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    idle_drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
